// File: rtl/road_sign_pkg.sv
// Shared road-sign definitions: display mode encodings, requester bit positions
// and the arbiter state type, used by the arbiter, road-sign top and pattern generators.
package road_sign_pkg;

    localparam int REQ_W       = 3;
    localparam int REQ_LEFT    = 0;
    localparam int REQ_RIGHT   = 1;
    localparam int REQ_WARNING = 2;

    typedef enum logic [1:0] {
        MODE_SAFE    = 2'd0,
        MODE_LEFT    = 2'd1,
        MODE_RIGHT   = 2'd2,
        MODE_WARNING = 2'd3
    } mode_e;

    typedef enum logic {
        ST_SAFE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_e;

    // One-hot grant pattern that belongs to a display mode; SAFE has no owner.
    function automatic logic [REQ_W-1:0] mode_to_grant(input mode_e m);
        logic [REQ_W-1:0] g;
        g = '0;
        case (m)
            MODE_LEFT:    g[REQ_LEFT]    = 1'b1;
            MODE_RIGHT:   g[REQ_RIGHT]   = 1'b1;
            MODE_WARNING: g[REQ_WARNING] = 1'b1;
            default:      g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sign_arbiter_if.sv
// Request/grant bundle between the sign arbiter (slave) and its requesters (master).
interface sign_arbiter_if;
    import road_sign_pkg::*;

    logic [REQ_W-1:0] req;
    logic             cancel;
    logic [REQ_W-1:0] grant;
    mode_e            mode;
    logic             tick;
    logic             busy;

    modport master (
        output req, cancel,
        input  grant, mode, tick, busy
    );

    modport slave (
        input  req, cancel,
        output grant, mode, tick, busy
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: emits a one-cycle tick each time the count wraps
// from MAX_COUNT-1 back to 0; the first tick lands MAX_COUNT cycles after reset.
module tick_gen #(
    parameter int MAX_COUNT = 62500000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int               CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/sign_arbiter.sv
// Road-sign display arbiter: grants LEFT/RIGHT/WARNING with a minimum dwell in ticks,
// WARNING preemption and cancel. Define ROUND_ROBIN_EN for fair LEFT/RIGHT ties.
module sign_arbiter
    import road_sign_pkg::*;
#(
    parameter int MAX_COUNT   = 62500000,
    parameter int DWELL_TICKS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    sign_arbiter_if.slave bus
);

    localparam logic [3:0] DWELL_MAX = 4'(DWELL_TICKS);

    arb_state_e       state;
    mode_e            mode_q;
    logic [REQ_W-1:0] grant_q;
    logic [3:0]       dwell;
    logic             tick;
    mode_e            pick_mode;
    logic             owner_req;
    logic             dwell_done;
    logic             preempt;
`ifdef ROUND_ROBIN_EN
    logic             favour_right;
`endif

    tick_gen #(
        .MAX_COUNT(MAX_COUNT)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pick_mode = MODE_SAFE;
        if (bus.req[REQ_WARNING]) begin
            pick_mode = MODE_WARNING;
        end
`ifdef ROUND_ROBIN_EN
        else if (bus.req[REQ_LEFT] && bus.req[REQ_RIGHT]) begin
            pick_mode = favour_right ? MODE_RIGHT : MODE_LEFT;
        end
`endif
        else if (bus.req[REQ_LEFT]) begin
            pick_mode = MODE_LEFT;
        end else if (bus.req[REQ_RIGHT]) begin
            pick_mode = MODE_RIGHT;
        end
    end

    assign owner_req  = |(bus.req & grant_q);
    assign dwell_done = (dwell == DWELL_MAX);
    // WARNING can only be high during a LEFT/RIGHT grant if it rose after that
    // grant was made, since it always wins arbitration in SAFE.
    assign preempt    = bus.req[REQ_WARNING] && (mode_q != MODE_WARNING);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_SAFE;
            mode_q       <= MODE_SAFE;
            grant_q      <= '0;
            dwell        <= '0;
`ifdef ROUND_ROBIN_EN
            favour_right <= 1'b0;
`endif
        end else if (bus.cancel) begin
            state   <= ST_SAFE;
            mode_q  <= MODE_SAFE;
            grant_q <= '0;
            dwell   <= '0;
        end else begin
            case (state)
                ST_SAFE: begin
                    if (|bus.req) begin
                        state   <= ST_ACTIVE;
                        mode_q  <= pick_mode;
                        grant_q <= mode_to_grant(pick_mode);
                        dwell   <= '0;
`ifdef ROUND_ROBIN_EN
                        if (pick_mode == MODE_LEFT) begin
                            favour_right <= 1'b1;
                        end else if (pick_mode == MODE_RIGHT) begin
                            favour_right <= 1'b0;
                        end
`endif
                    end
                end
                ST_ACTIVE: begin
                    if (preempt) begin
                        mode_q  <= MODE_WARNING;
                        grant_q <= mode_to_grant(MODE_WARNING);
                        dwell   <= '0;
                    end else if (!owner_req && dwell_done) begin
                        state   <= ST_SAFE;
                        mode_q  <= MODE_SAFE;
                        grant_q <= '0;
                        dwell   <= '0;
                    end else if (tick && !dwell_done) begin
                        dwell <= dwell + 4'd1;
                    end
                end
                default: begin
                    state   <= ST_SAFE;
                    mode_q  <= MODE_SAFE;
                    grant_q <= '0;
                    dwell   <= '0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.mode  = mode_q;
    assign bus.tick  = tick;
    assign bus.busy  = (mode_q != MODE_SAFE);

endmodule
